// File: rtl/cu_pkg.sv
`default_nettype none
// ============================================================================
// cu_pkg : opcodes, control-bundle layout and FSM encoding for the ID issuer
// Rev 1.0
// ============================================================================
package cu_pkg;

    localparam logic [6:0] OP_R       = 7'b0110011;
    localparam logic [6:0] OP_IMM     = 7'b0010011;
    localparam logic [6:0] OP_LOAD    = 7'b0000011;
    localparam logic [6:0] OP_STORE   = 7'b0100011;
    localparam logic [6:0] OP_BRANCH  = 7'b1100011;
    localparam logic [6:0] OP_JAL     = 7'b1101111;
    localparam logic [6:0] OP_JALR    = 7'b1100111;
    localparam logic [6:0] OP_LUI     = 7'b0110111;
    localparam logic [6:0] OP_AUIPC   = 7'b0010111;
    localparam logic [6:0] NOP_OPCODE = 7'b0000000;

    // Bundle layout {regWrite, memRead, memWrite, memToReg, aluSrc, branch, jump, aluOp[1:0]}
    localparam int CTRL_W        = 9;
    localparam int CTRL_REGWRITE = 8;
    localparam int CTRL_MEMREAD  = 7;
    localparam int CTRL_MEMWRITE = 6;
    localparam int CTRL_MEMTOREG = 5;
    localparam int CTRL_ALUSRC   = 4;
    localparam int CTRL_BRANCH   = 3;
    localparam int CTRL_JUMP     = 2;
    localparam int CTRL_ALUOP_HI = 1;
    localparam int CTRL_ALUOP_LO = 0;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_BR    = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_PASS  = 2'b11;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        TRAP  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/cu_decode.sv
`default_nettype none
// ============================================================================
// cu_decode : opcode -> control bundle, illegal flag and source-register usage
// Rev 1.0
// ============================================================================
module cu_decode
    import cu_pkg::*;
(
    input  logic [6:0]        opcode,
    output logic [CTRL_W-1:0] ctrl,
    output logic              illegal_op,
    output logic              rs1_used,
    output logic              rs2_used
);

    always_comb begin
        ctrl       = '0;
        illegal_op = 1'b0;
        rs1_used   = 1'b0;
        rs2_used   = 1'b0;
        case (opcode)
            OP_R: begin
                ctrl[CTRL_REGWRITE]                = 1'b1;
                ctrl[CTRL_ALUOP_HI:CTRL_ALUOP_LO]  = ALUOP_FUNCT;
                rs1_used = 1'b1;
                rs2_used = 1'b1;
            end
            OP_IMM: begin
                ctrl[CTRL_REGWRITE]                = 1'b1;
                ctrl[CTRL_ALUSRC]                  = 1'b1;
                ctrl[CTRL_ALUOP_HI:CTRL_ALUOP_LO]  = ALUOP_FUNCT;
                rs1_used = 1'b1;
            end
            OP_LOAD: begin
                ctrl[CTRL_REGWRITE] = 1'b1;
                ctrl[CTRL_MEMREAD]  = 1'b1;
                ctrl[CTRL_MEMTOREG] = 1'b1;
                ctrl[CTRL_ALUSRC]   = 1'b1;
                rs1_used = 1'b1;
            end
            OP_STORE: begin
                ctrl[CTRL_MEMWRITE] = 1'b1;
                ctrl[CTRL_ALUSRC]   = 1'b1;
                rs1_used = 1'b1;
                rs2_used = 1'b1;
            end
            OP_BRANCH: begin
                ctrl[CTRL_BRANCH]                  = 1'b1;
                ctrl[CTRL_ALUOP_HI:CTRL_ALUOP_LO]  = ALUOP_BR;
                rs1_used = 1'b1;
                rs2_used = 1'b1;
            end
            OP_JAL, OP_JALR: begin
                ctrl[CTRL_REGWRITE] = 1'b1;
                ctrl[CTRL_ALUSRC]   = 1'b1;
                ctrl[CTRL_JUMP]     = 1'b1;
                // JAL is PC-relative only; JALR reads its base from rs1
                rs1_used = (opcode == OP_JALR);
            end
            OP_LUI, OP_AUIPC: begin
                ctrl[CTRL_REGWRITE]                = 1'b1;
                ctrl[CTRL_ALUSRC]                  = 1'b1;
                ctrl[CTRL_ALUOP_HI:CTRL_ALUOP_LO]  = ALUOP_PASS;
            end
            default: illegal_op = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/cu_id_issue.sv
`default_nettype none
// ============================================================================
// cu_id_issue : decode-stage issuer with load-use stall, flush and illegal trap
// Rev 1.0
// ============================================================================
module cu_id_issue
    import cu_pkg::*;
#(
    parameter int         XLEN       = 32,
    parameter logic [6:0] NOP_OPCODE = 7'b0000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [XLEN-1:0]   IDinstr,
    input  logic              IDvalid,
    input  logic              EXmemRead,
    input  logic [4:0]        EXrd,
    input  logic              flush,
    output logic [6:0]        CUEXopcode,
    output logic [CTRL_W-1:0] CUEXctrl,
    output logic [4:0]        CUEXrd,
    output logic [4:0]        CUEXrs1,
    output logic [4:0]        CUEXrs2,
    output logic              stall,
    output logic              illegal
);

    state_t state;

    logic [6:0]        id_opcode;
    logic [4:0]        id_rd;
    logic [4:0]        id_rs1;
    logic [4:0]        id_rs2;
    logic [CTRL_W-1:0] dec_ctrl;
    logic              dec_illegal;
    logic              rs1_used;
    logic              rs2_used;
    logic              loaduse;
    logic              accept;
    logic              issue;
    logic              enter_trap;
    logic              unused_bits;

    assign id_opcode   = IDinstr[6:0];
    assign id_rd       = IDinstr[11:7];
    assign id_rs1      = IDinstr[19:15];
    assign id_rs2      = IDinstr[24:20];
    assign unused_bits = ^{IDinstr[XLEN-1:25], IDinstr[14:12]};

    cu_decode u_decode (
        .opcode     (id_opcode),
        .ctrl       (dec_ctrl),
        .illegal_op (dec_illegal),
        .rs1_used   (rs1_used),
        .rs2_used   (rs2_used)
    );

    assign loaduse = EXmemRead & (EXrd != 5'd0) & IDvalid &
                     ((rs1_used & (EXrd == id_rs1)) | (rs2_used & (EXrd == id_rs2)));

    // The STALL state has already paid its one bubble, so loaduse is ignored there
    assign accept     = IDvalid & ~flush &
                        (((state == RUN) & ~loaduse) | (state == STALL));
    assign issue      = accept & ~dec_illegal;
    assign enter_trap = accept & dec_illegal;

    assign stall = (state == TRAP) | ((state == RUN) & ~flush & loaduse);

    always_ff @(negedge clk) begin
        if (!reset) begin
            state      <= RUN;
            CUEXopcode <= NOP_OPCODE;
            CUEXctrl   <= '0;
            CUEXrd     <= '0;
            CUEXrs1    <= '0;
            CUEXrs2    <= '0;
            illegal    <= 1'b0;
        end else begin
            if (issue) begin
                CUEXopcode <= id_opcode;
                CUEXctrl   <= dec_ctrl;
                CUEXrd     <= id_rd;
                CUEXrs1    <= id_rs1;
                CUEXrs2    <= id_rs2;
            end else begin
                CUEXopcode <= NOP_OPCODE;
                CUEXctrl   <= '0;
                CUEXrd     <= '0;
                CUEXrs1    <= '0;
                CUEXrs2    <= '0;
            end

            case (state)
                RUN: begin
                    if (enter_trap) begin
                        state   <= TRAP;
                        illegal <= 1'b1;
                    end else if (!flush && loaduse) begin
                        state <= STALL;
                    end
                end
                STALL: begin
                    if (enter_trap) begin
                        state   <= TRAP;
                        illegal <= 1'b1;
                    end else begin
                        state <= RUN;
                    end
                end
                TRAP:    state <= TRAP;
                default: state <= RUN;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cu_id_issue.sv
`default_nettype none
// ============================================================================
// tb_cu_id_issue : scoreboard bench for the decode-stage issuer
// Rev 1.0
// ============================================================================
module tb_cu_id_issue;

    typedef struct packed {
        logic [6:0] op;
        logic [8:0] ctrl;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } exp_t;

    localparam logic [31:0] ADD_X0_X1_X2 = 32'h00208033;
    localparam logic [31:0] ADD_X3_X5_X6 = 32'h006281B3;
    localparam logic [31:0] ADD_X3_X0_X6 = 32'h006001B3;
    localparam logic [31:0] SW_X5_X2     = 32'h00512023;
    localparam logic [31:0] LUI_X5       = 32'h000282B7;
    localparam logic [31:0] JAL_X5       = 32'h000282EF;
    localparam logic [31:0] ADDI_X1_X2_5 = 32'h00510093;
    localparam logic [31:0] BEQ_X1_X2    = 32'h00208063;
    localparam logic [31:0] LW_X7_X8     = 32'h00442383;
    localparam logic [31:0] JALR_X1_X5   = 32'h000280E7;
    localparam logic [31:0] AUIPC_X4     = 32'h00001217;
    localparam logic [31:0] BAD_OP       = 32'h0000007F;

    logic        clk;
    logic        reset;
    logic [31:0] IDinstr;
    logic        IDvalid;
    logic        EXmemRead;
    logic [4:0]  EXrd;
    logic        flush;
    logic [6:0]  CUEXopcode;
    logic [8:0]  CUEXctrl;
    logic [4:0]  CUEXrd;
    logic [4:0]  CUEXrs1;
    logic [4:0]  CUEXrs2;
    logic        stall;
    logic        illegal;

    exp_t got;
    exp_t sb[$];
    int   vectors;
    int   miscompares;

    assign got = {CUEXopcode, CUEXctrl, CUEXrd, CUEXrs1, CUEXrs2};

    cu_id_issue dut (
        .clk        (clk),
        .reset      (reset),
        .IDinstr    (IDinstr),
        .IDvalid    (IDvalid),
        .EXmemRead  (EXmemRead),
        .EXrd       (EXrd),
        .flush      (flush),
        .CUEXopcode (CUEXopcode),
        .CUEXctrl   (CUEXctrl),
        .CUEXrd     (CUEXrd),
        .CUEXrs1    (CUEXrs1),
        .CUEXrs2    (CUEXrs2),
        .stall      (stall),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference decode table written straight from the RV32I control listing
    function automatic exp_t expect_issue(input logic [31:0] ins);
        exp_t e;
        e.op  = ins[6:0];
        e.rd  = ins[11:7];
        e.rs1 = ins[19:15];
        e.rs2 = ins[24:20];
        case (ins[6:0])
            7'b0110011: e.ctrl = 9'b100000010;
            7'b0010011: e.ctrl = 9'b100010010;
            7'b0000011: e.ctrl = 9'b110110000;
            7'b0100011: e.ctrl = 9'b001010000;
            7'b1100011: e.ctrl = 9'b000001001;
            7'b1101111: e.ctrl = 9'b100010100;
            7'b1100111: e.ctrl = 9'b100010100;
            7'b0110111: e.ctrl = 9'b100010011;
            7'b0010111: e.ctrl = 9'b100010011;
            default:    e.ctrl = 9'b000000000;
        endcase
        return e;
    endfunction

    function automatic exp_t bubble();
        exp_t e;
        e = '0;
        return e;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        repeat (2) tick();
        vectors++;
        if (got !== bubble()) begin
            miscompares++;
            $display("FAIL reset_bundle: got %h want %h", got, bubble());
        end
        vectors++;
        if (illegal !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_illegal: got %b want 0", illegal);
        end
        reset = 1'b1;
        sb.push_back(expect_issue(ADD_X0_X1_X2));
        tick();
        e = sb.pop_front();
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL reset_release_issue: got %h want %h", got, e);
        end
        vectors++;
        if (CUEXctrl !== 9'b100000010 || CUEXopcode !== 7'b0110011) begin
            miscompares++;
            $display("FAIL reset_release_add: got op=%b ctrl=%b want op=0110011 ctrl=100000010",
                     CUEXopcode, CUEXctrl);
        end
    endtask

    task automatic test_load_use();
        exp_t e;
        logic [31:0] instrs [2];
        instrs[0] = ADD_X3_X5_X6;
        instrs[1] = SW_X5_X2;
        for (int i = 0; i < 2; i++) begin
            IDinstr = instrs[i]; IDvalid = 1'b1; EXmemRead = 1'b1; EXrd = 5'd5;
            #1;
            vectors++;
            if (stall !== 1'b1) begin
                miscompares++;
                $display("FAIL loaduse_stall_%0d: got %b want 1", i, stall);
            end
            sb.push_back(bubble());
            tick();
            e = sb.pop_front();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL loaduse_bubble_%0d: got %h want %h", i, got, e);
            end
            // EX still reports the load on the first case: only one bubble is owed
            if (i == 1) EXmemRead = 1'b0;
            #1;
            vectors++;
            if (stall !== 1'b0) begin
                miscompares++;
                $display("FAIL loaduse_release_%0d: got %b want 0", i, stall);
            end
            sb.push_back(expect_issue(instrs[i]));
            tick();
            e = sb.pop_front();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL loaduse_issue_%0d: got %h want %h", i, got, e);
            end
        end
        EXmemRead = 1'b0;
    endtask

    task automatic test_no_hazard();
        exp_t e;
        logic [31:0] instrs [4];
        instrs[0] = ADD_X3_X0_X6;
        instrs[1] = LUI_X5;
        instrs[2] = JAL_X5;
        instrs[3] = ADDI_X1_X2_5;
        for (int i = 0; i < 4; i++) begin
            IDinstr = instrs[i]; IDvalid = 1'b1; EXmemRead = 1'b1;
            EXrd = (i == 0) ? 5'd0 : 5'd5;
            #1;
            vectors++;
            if (stall !== 1'b0) begin
                miscompares++;
                $display("FAIL nohazard_stall_%0d: got %b want 0", i, stall);
            end
            sb.push_back(expect_issue(instrs[i]));
            tick();
            e = sb.pop_front();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL nohazard_issue_%0d: got %h want %h", i, got, e);
            end
        end
        EXmemRead = 1'b0;
    endtask

    task automatic test_flush();
        exp_t e;
        // flush in RUN against a live load-use: flush wins, no stall
        IDinstr = ADD_X3_X5_X6; IDvalid = 1'b1; EXmemRead = 1'b1; EXrd = 5'd5; flush = 1'b1;
        #1;
        vectors++;
        if (stall !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_run_stall: got %b want 0", stall);
        end
        sb.push_back(bubble());
        tick();
        e = sb.pop_front();
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL flush_run_bubble: got %h want %h", got, e);
        end
        flush = 1'b0; EXmemRead = 1'b0; IDinstr = BEQ_X1_X2;
        sb.push_back(expect_issue(BEQ_X1_X2));
        tick();
        e = sb.pop_front();
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL flush_run_next: got %h want %h", got, e);
        end
        // flush arriving while in STALL squashes the held instruction
        IDinstr = ADD_X3_X5_X6; EXmemRead = 1'b1;
        sb.push_back(bubble());
        tick();
        e = sb.pop_front();
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL flush_stall_first: got %h want %h", got, e);
        end
        flush = 1'b1;
        #1;
        vectors++;
        if (stall !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_stall_stall: got %b want 0", stall);
        end
        sb.push_back(bubble());
        tick();
        e = sb.pop_front();
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL flush_stall_squash: got %h want %h", got, e);
        end
        flush = 1'b0; EXmemRead = 1'b0; IDinstr = BEQ_X1_X2;
        sb.push_back(expect_issue(BEQ_X1_X2));
        tick();
        e = sb.pop_front();
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL flush_stall_next: got %h want %h", got, e);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [31:0] instrs [5];
        instrs[0] = LW_X7_X8;
        instrs[1] = JALR_X1_X5;
        instrs[2] = AUIPC_X4;
        instrs[3] = ADD_X3_X5_X6;
        instrs[4] = SW_X5_X2;
        EXmemRead = 1'b0; IDvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            IDinstr = instrs[i];
            sb.push_back(expect_issue(instrs[i]));
            tick();
            e = sb.pop_front();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL b2b_issue_%0d: got %h want %h", i, got, e);
            end
        end
    endtask

    task automatic test_invalid();
        exp_t e;
        IDvalid = 1'b0; IDinstr = 32'hFFFFFFFF;
        #1;
        vectors++;
        if (stall !== 1'b0) begin
            miscompares++;
            $display("FAIL invalid_stall: got %b want 0", stall);
        end
        sb.push_back(bubble());
        tick();
        e = sb.pop_front();
        vectors++;
        if (got !== e || illegal !== 1'b0) begin
            miscompares++;
            $display("FAIL invalid_bubble: got %h ill=%b want %h ill=0", got, illegal, e);
        end
        IDvalid = 1'b1;
    endtask

    task automatic test_trap();
        exp_t e;
        IDinstr = BAD_OP; IDvalid = 1'b1;
        sb.push_back(bubble());
        tick();
        e = sb.pop_front();
        vectors++;
        if (got !== e || illegal !== 1'b1) begin
            miscompares++;
            $display("FAIL trap_entry: got %h ill=%b want %h ill=1", got, illegal, e);
        end
        for (int i = 0; i < 10; i++) begin
            IDinstr = i[0] ? ADD_X3_X5_X6 : BAD_OP;
            flush = (i == 4);
            #1;
            vectors++;
            if (stall !== 1'b1) begin
                miscompares++;
                $display("FAIL trap_stall_%0d: got %b want 1", i, stall);
            end
            sb.push_back(bubble());
            tick();
            e = sb.pop_front();
            vectors++;
            if (got !== e || illegal !== 1'b1) begin
                miscompares++;
                $display("FAIL trap_hold_%0d: got %h ill=%b want %h ill=1", i, got, illegal, e);
            end
        end
        flush = 1'b0;
        reset = 1'b0; IDinstr = ADD_X3_X5_X6;
        sb.push_back(bubble());
        tick();
        e = sb.pop_front();
        vectors++;
        if (got !== e || illegal !== 1'b0) begin
            miscompares++;
            $display("FAIL trap_reset: got %h ill=%b want %h ill=0", got, illegal, e);
        end
        reset = 1'b1;
        #1;
        vectors++;
        if (stall !== 1'b0) begin
            miscompares++;
            $display("FAIL trap_exit_stall: got %b want 0", stall);
        end
        sb.push_back(expect_issue(ADD_X3_X5_X6));
        tick();
        e = sb.pop_front();
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL trap_exit_issue: got %h want %h", got, e);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        IDinstr     = ADD_X0_X1_X2;
        IDvalid     = 1'b1;
        EXmemRead   = 1'b0;
        EXrd        = 5'd0;
        flush       = 1'b0;
        test_reset();
        test_load_use();
        test_no_hazard();
        test_flush();
        test_back_to_back();
        test_invalid();
        test_trap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
